// File: rtl/stack_inst_fetch.sv
// Instruction-fetch controller in front of stack_cpu: owns the instruction RAM port,
// fetches the word at the CPU's next PC and lets a loader fill the RAM while halted.
module stack_inst_fetch #(
  parameter int CPU_BIT_WIDTH = 32,
  parameter int RESET_PC      = 0,
  parameter int RAM_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     inst_complete,
  input  logic [CPU_BIT_WIDTH-1:0] pc_next,
  output logic [CPU_BIT_WIDTH-1:0] inst,
  output logic                     inst_ready,
  output logic [CPU_BIT_WIDTH-1:0] pc_fetch,
  output logic [CPU_BIT_WIDTH-1:0] fetch_count,
  input  logic                     load_valid,
  input  logic [CPU_BIT_WIDTH-1:0] load_addr,
  input  logic [CPU_BIT_WIDTH-1:0] load_data,
  output logic                     load_ready,
  output logic [3:0]               ram_we,
  output logic [CPU_BIT_WIDTH-1:0] ram_addr,
  output logic [CPU_BIT_WIDTH-1:0] ram_data_in,
  input  logic [CPU_BIT_WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, WAIT, PRESENT, EXEC} state_t;

  typedef struct packed {
    logic                     valid;
    logic [CPU_BIT_WIDTH-1:0] addr;
    logic [CPU_BIT_WIDTH-1:0] data;
  } load_req_t;

  state_t                   state;
  logic [2:0]               cnt;
  logic [CPU_BIT_WIDTH-1:0] pc;
  load_req_t                ld;

  assign ld = '{valid: load_valid, addr: load_addr, data: load_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pc          <= CPU_BIT_WIDTH'(RESET_PC);
      inst        <= '0;
      inst_ready  <= 1'b0;
      pc_fetch    <= '0;
      fetch_count <= '0;
      load_ready  <= 1'b0;
      ram_we      <= '0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      inst_ready <= 1'b0;
      load_ready <= 1'b0;
      ram_we     <= '0;
      case (state)
        IDLE: begin
          if (run) begin
            ram_addr <= pc;
            cnt      <= 3'(RAM_LATENCY);
            state    <= WAIT;
          end else if (ld.valid && !load_ready) begin
            // load_ready gating spaces a held request to one write per two cycles
            ram_we      <= 4'b1111;
            ram_addr    <= ld.addr;
            ram_data_in <= ld.data;
            load_ready  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            inst        <= ram_data_out;
            pc_fetch    <= pc;
            inst_ready  <= 1'b1;
            fetch_count <= fetch_count + CPU_BIT_WIDTH'(1);
            state       <= PRESENT;
          end
        end
        PRESENT, EXEC: begin
          // completion during the presentation cycle behaves exactly as in EXEC
          if (inst_complete) begin
            pc <= pc_next;
            if (run) begin
              ram_addr <= pc_next;
              cnt      <= 3'(RAM_LATENCY);
              state    <= WAIT;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= EXEC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stack_inst_fetch.md
Name: stack_inst_fetch

Overview:
Synthesizable instruction-fetch controller that sits directly upstream of stack_cpu. It owns the instruction RAM (stack_cpu_ram interface) and reads the word at the CPU-supplied next PC after each completed instruction. It presents that word to the CPU with a one-cycle inst_ready pulse. While the CPU is not running, a loader port lets software (EDK side) write instruction words into the RAM.

Parameters:
CPU_BIT_WIDTH, 32, instruction / data / address width
RESET_PC, 0, word address of the first fetch after reset
RAM_LATENCY, 1, cycles from the RAM sampling an address to douta valid (1..7)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
run  in  1  1 = fetch and execute; 0 = halt and allow loading
inst_complete  in  1  CPU finished the current instruction; pc_next is valid
pc_next  in  CPU_BIT_WIDTH  next fetch address from the CPU
inst  out  CPU_BIT_WIDTH  instruction presented to the CPU
inst_ready  out  1  one-cycle pulse: inst is valid
pc_fetch  out  CPU_BIT_WIDTH  address of the instruction currently held in inst
fetch_count  out  CPU_BIT_WIDTH  number of instructions delivered (wraps)
load_valid  in  1  loader write request
load_addr  in  CPU_BIT_WIDTH  loader write address
load_data  in  CPU_BIT_WIDTH  loader write data
load_ready  out  1  loader request accepted this cycle
ram_we  out  4  RAM byte write enable
ram_addr  out  CPU_BIT_WIDTH  RAM address
ram_data_in  out  CPU_BIT_WIDTH  RAM write data
ram_data_out  in  CPU_BIT_WIDTH  RAM read data

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, pc=RESET_PC, and every output is 0 (inst, inst_ready, pc_fetch, fetch_count, load_ready, ram_we, ram_addr, ram_data_in). Reset mid-fetch abandons the fetch with no inst_ready pulse.
- All outputs are registered.
- The RAM is word-addressed, so ram_addr = pc unmodified.
- States are IDLE, WAIT, PRESENT and EXEC.
- IDLE, run=0:
  - load_valid=1 at an edge registers ram_we=4'b1111, ram_addr=load_addr, ram_data_in=load_data and load_ready=1 for exactly one cycle.
  - The next edge clears ram_we and load_ready.
  - A held load_valid writes once per two cycles.
- IDLE, run=1: ram_we=0, ram_addr=pc, cnt=RAM_LATENCY, go to WAIT. The run=1 branch takes priority over load_valid, and any pending load is ignored.
- WAIT:
  - cnt>0: cnt decrements.
  - cnt==0: inst=ram_data_out, pc_fetch=pc, inst_ready=1, fetch_count+=1, go to PRESENT.
  - inst_ready therefore rises RAM_LATENCY+1 edges after the address-issuing edge (2 cycles at the default).
- PRESENT: inst_ready returns to 0 at the next edge and the state goes to EXEC. inst_complete sampled in PRESENT is treated as in EXEC.
- EXEC: inst holds its value. On inst_complete=1: pc=pc_next.
  - If run=1: ram_addr=pc_next, cnt=RAM_LATENCY, go to WAIT.
  - If run=0: go to IDLE. The next run=1 resumes from the saved pc.
- inst_complete in IDLE or WAIT is ignored.
- run dropping in WAIT does not abort the fetch. The instruction is delivered, and the halt takes effect at the next inst_complete.
- inst_ready never asserts on two consecutive cycles. Exactly one pulse is produced per fetch.
- fetch_count wraps from 2^CPU_BIT_WIDTH-1 to 0. It is not cleared by run, only by reset.
- pc_next is used unmodified, with no range check; address wrap is the RAM's concern.

Test Plan:
- Reset with run=0: all outputs 0. Load addr 0 = 0xA0000001 and addr 1 = 0xB0000002 -> one load_ready pulse per write, ram_we=4'b1111 for one cycle each.
- After the loads, raise run -> ram_addr=0; inst_ready pulses 2 cycles later with inst=0xA0000001, pc_fetch=0, fetch_count=1.
- Pulse inst_complete with pc_next=1 -> inst_ready pulses 2 cycles later with inst=0xB0000002, pc_fetch=1, fetch_count=2. inst_complete pulsed again during WAIT -> ignored, no extra fetch.
- Drop run during WAIT, then pulse inst_complete with pc_next=0 -> instruction is still delivered, the controller returns to IDLE, and a load is now accepted. Raise run -> fetch resumes at addr 0.
- Assert rst_n=0 during WAIT -> no inst_ready pulse, all outputs 0, pc=RESET_PC.
- RAM_LATENCY=3 build -> inst_ready rises exactly 4 edges after the address-issuing edge.
